port_uart_tx: RTL and testbench
===============================

Name: port_uart_tx

Overview:
- UART transmitter downstream of the MCU output port.
- Captures the low byte of the MCU's 16-bit port output on each rising edge of the MCU's single-pin output, which serves as the write strobe.
- Buffers captured bytes in a small FIFO and serialises them as 8N1 frames on txd.
- The 16-bit status word is wired back to the MCU port input so firmware can poll busy/full/overflow.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.
- FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- port_data  input  16  MCU port output; only bits [7:0] are used.
- wr_strobe  input  1  MCU pin output; push on 0->1 transition.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- txd  output  1  serial data; idle high.
- busy  output  1  frame in progress, or FIFO not empty.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- status  output  16  {12'b0, overflow, fifo_full, fifo_empty, busy}, bits [3:0].

Behaviour:
- Reset (async, rst=1), applied immediately including mid-frame:
  - txd=1, busy=0, fifo_full=0, overflow=0, fifo_empty=1.
  - strobe_q=0, FSM=IDLE, FIFO pointers and count = 0.
  - A partially sent frame is abandoned; the line returns high at once.
- Strobe edge detection:
  - strobe_q is a register of wr_strobe.
  - push = wr_strobe & ~strobe_q.
  - A held-high strobe pushes exactly once.
- Push at edge k: port_data[7:0] is written at that edge.
  - If the FIFO is full and no pop occurs at edge k, the byte is dropped and overflow is set.
  - If full and a pop occurs at the same edge, the push is accepted and count is unchanged.
- overflow is sticky; clr_ovf=1 clears it at the next edge.
  - If overflow set and clr_ovf coincide in the same cycle, set wins.
- Simultaneous push and pop in any non-full state: both occur, count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - A baud counter runs 0..CLKS_PER_BIT-1 and generates bit_done on its terminal value.
  - A 3-bit bit index is used in DATA.
- IDLE:
  - txd=1.
  - If FIFO not empty: pop head into shift register, clear baud counter, txd=0 from the next edge, go to START.
  - Push at edge k into an empty FIFO -> pop at edge k+1 -> txd low during cycle k+1.
- START: txd=0 for CLKS_PER_BIT cycles; on bit_done -> DATA, bit index 0.
- DATA:
  - txd = shift[0], LSB first.
  - On bit_done: shift right; at index 7 -> STOP, otherwise index+1.
- STOP: txd=1 for CLKS_PER_BIT cycles. On bit_done:
  - if FIFO not empty, pop and go directly to START with no idle gap;
  - otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- busy = (FSM != IDLE) | ~fifo_empty, registered-state derived, no comb path from wr_strobe.
- fifo_full/fifo_empty are derived from the registered count (0..FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH.
- port_data[15:8] is ignored.

Optional Feature:
- Macro: PORT_UART_TX_PARITY_EN.
- Defined:
  - FSM gains state PARITY between DATA and STOP.
  - txd = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame is 11*CLKS_PER_BIT cycles.
  - status[4]=1 marks the parity build.
- Undefined: no PARITY state, 8N1 framing, status[4]=0.

Test Plan:
- Single byte (CLKS_PER_BIT=4): port_data=16'h12A5, strobe pulse at edge k.
  - txd low from k+1 for 4 cycles.
  - Then bits 1,0,1,0,0,1,0,1 at 4 cycles each.
  - Then high for 4 cycles.
  - busy falls at k+41; status=16'h0002 afterwards.
- Held strobe: wr_strobe high for 50 cycles with data 8'h3C.
  - Exactly one frame is sent; FIFO count never exceeds 1.
- Back-to-back: 3 strobes, 2 cycles apart, bytes 8'h01, 8'h02, 8'h03.
  - Three contiguous frames over 120 cycles; txd has no idle-high gap beyond the stop bits.
- Overflow: 6 strobes, 2 cycles apart, during the first frame (depth 4).
  - First byte popped, next 4 buffered, 6th dropped.
  - fifo_full=1 and overflow=1 (status bit3).
  - clr_ovf pulse clears bit3 only; 5 frames are transmitted.
- Reset mid-frame: assert rst during DATA bit 3.
  - txd=1, busy=0, status=16'h0002 immediately, without waiting for a clock.
  - After release, a new strobe with 8'hFF yields a clean full frame.
- With PORT_UART_TX_PARITY_EN: byte 8'h07.
  - Parity bit 1 follows the data bits.
  - Frame length is 44 cycles at CLKS_PER_BIT=4.
  - status[4]=1.

Source files
------------

// File: rtl/port_uart_tx.sv
// port_uart_tx: byte-wide UART transmitter fed by an MCU port strobe.
// Build option PORT_UART_TX_PARITY_EN adds an even-parity bit per frame.
`timescale 1ns/1ps

module port_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] port_data,
    input  logic        wr_strobe,
    input  logic        clr_ovf,
    output logic        txd,
    output logic        busy,
    output logic        fifo_full,
    output logic [15:0] status
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

`ifdef PORT_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
    localparam logic LP_PAR_BUILD = 1'b1;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
    localparam logic LP_PAR_BUILD = 1'b0;
`endif

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_strobe_q;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_ovf;

    logic [7:0]      r_shift;
    logic [2:0]      r_bit_idx;
    logic [BW-1:0]   r_baud;
`ifdef PORT_UART_TX_PARITY_EN
    logic            r_par;
`endif

    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_push_ok;
    logic            w_ovf_set;
    logic            w_pop;
    logic            w_bit_done;
    logic            w_txd;
    logic            w_unused_hi;

    // The upper port byte carries no information for this block.
    assign w_unused_hi = ^port_data[15:8];

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_FULL);
    assign w_push     = wr_strobe & ~r_strobe_q;
    assign w_bit_done = (r_baud == BAUD_LAST);

    // A full FIFO still accepts a byte when a slot frees up at the same edge.
    assign w_push_ok  = w_push & (~w_full | w_pop);
    assign w_ovf_set  = w_push & w_full & ~w_pop;

    // Next-state, pop request and line level from the registered state.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_txd       = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_txd = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_txd = 1'b0;
                if (w_bit_done) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_txd = r_shift[0];
                if (w_bit_done && (r_bit_idx == 3'd7)) begin
`ifdef PORT_UART_TX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef PORT_UART_TX_PARITY_EN
            S_PARITY: begin
                w_txd = r_par;
                if (w_bit_done) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                w_txd = 1'b1;
                if (w_bit_done) begin
                    if (!w_empty) begin
                        // Chain straight into the next start bit.
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_txd       = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Strobe edge detect, FIFO pointers/occupancy and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe_q <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_strobe_q <= wr_strobe;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= port_data[7:0];
        end
    end

    // Baud timing, bit index and the outgoing shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
`ifdef PORT_UART_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            if ((r_state == S_IDLE) || w_bit_done) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + BW'(1);
            end
            if (r_state != S_DATA) begin
                r_bit_idx <= 3'd0;
            end else if (w_bit_done) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
`ifdef PORT_UART_TX_PARITY_EN
                r_par   <= ^r_mem[r_rd_ptr];
`endif
            end else if ((r_state == S_DATA) && w_bit_done) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
        end
    end

    assign txd       = w_txd;
    assign busy      = (r_state != S_IDLE) | ~w_empty;
    assign fifo_full = w_full;
    assign status    = {11'd0, LP_PAR_BUILD, r_ovf, w_full, w_empty, busy};

endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx: scoreboard bench for port_uart_tx at CLKS_PER_BIT=4.
// A line monitor decodes frames; each test compares against queued bytes.
`timescale 1ns/1ps

module tb_port_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef PORT_UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [15:0] PAR_ST = 16'h0010;
`else
    localparam int NB = 10;
    localparam logic [15:0] PAR_ST = 16'h0000;
`endif
    localparam int FRAME = NB * CPB;
    localparam logic [15:0] IDLE_ST = 16'h0002 | PAR_ST;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] port_data = 16'h0000;
    logic        wr_strobe = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        txd;
    logic        busy;
    logic        fifo_full;
    logic [15:0] status;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] exp_q [$];
    logic [7:0] rx_data [$];
    bit         rx_ok [$];
    int         rx_start [$];

    port_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .port_data(port_data),
        .wr_strobe(wr_strobe),
        .clr_ovf(clr_ovf),
        .txd(txd),
        .busy(busy),
        .fifo_full(fifo_full),
        .status(status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: samples each bit mid-cell, abandons a frame on reset.
    initial begin : monitor
        logic [NB-1:0] bits;
        bit aborted;
        bit good;
        int st;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                st = cyc;
                aborted = 1'b0;
                bits = '0;
                for (int c = 0; c < FRAME; c++) begin
                    if (c != 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c % CPB == CPB / 2) bits[c / CPB] = txd;
                end
                if (!aborted) begin
                    good = (bits[0] == 1'b0) && (bits[NB-1] == 1'b1);
`ifdef PORT_UART_TX_PARITY_EN
                    good = good && (bits[9] == ^bits[8:1]);
`endif
                    rx_data.push_back(bits[8:1]);
                    rx_ok.push_back(good);
                    rx_start.push_back(st);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic strobe(input logic [15:0] pd, input bit accept);
        @(negedge clk);
        port_data = pd;
        wr_strobe = 1'b1;
        if (accept) exp_q.push_back(pd[7:0]);
        @(negedge clk);
        wr_strobe = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit expired);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        expired = (busy !== 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || fifo_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_pins txd=%b busy=%b full=%b want 1 0 0",
                     txd, busy, fifo_full);
        end
        checks++;
        if (status !== IDLE_ST) begin
            failures++;
            $display("FAIL reset_status got=%h want=%h", status, IDLE_ST);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (status !== IDLE_ST || txd !== 1'b1) begin
            failures++;
            $display("FAIL reset_release status=%h txd=%b want=%h 1",
                     status, txd, IDLE_ST);
        end
    endtask

    task automatic check_wave(input logic [15:0] pd, input string nm);
        logic [7:0] d;
        logic e;
        int bi;
        bit to;
        d = pd[7:0];
        strobe(pd, 1'b1);
        checks++;
        if (txd !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_after_push txd=%b busy=%b want 1 1", nm, txd, busy);
        end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            bi = i / CPB;
            if (bi == 0) e = 1'b0;
            else if (bi <= 8) e = d[bi-1];
            else if (NB == 11 && bi == 9) e = ^d;
            else e = 1'b1;
            checks++;
            if (txd !== e) begin
                failures++;
                $display("FAIL %s_txd cycle=%0d got=%b want=%b", nm, i, txd, e);
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy_last got=%b want=1", nm, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || status !== IDLE_ST) begin
            failures++;
            $display("FAIL %s_end busy=%b status=%h want 0 %h",
                     nm, busy, status, IDLE_ST);
        end
        wait_idle(20, to);
        checks++;
        if (rx_data.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_count got=%0d want=%0d",
                     nm, rx_data.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && rx_data.size() != 0) begin
            logic [7:0] ev, gv;
            bit ok;
            ev = exp_q.pop_front();
            gv = rx_data.pop_front();
            ok = rx_ok.pop_front();
            checks++;
            if (gv !== ev || !ok) begin
                failures++;
                $display("FAIL %s_byte got=%h framing=%0d want=%h", nm, gv, ok, ev);
            end
        end
        exp_q.delete(); rx_data.delete(); rx_ok.delete(); rx_start.delete();
    endtask

    task automatic test_single;
        check_wave(16'h12A5, "single");
    endtask

    task automatic test_held;
        bit full_seen = 1'b0;
        bit to;
        @(negedge clk);
        port_data = 16'h003C;
        wr_strobe = 1'b1;
        exp_q.push_back(8'h3C);
        repeat (50) begin
            @(negedge clk);
            if (fifo_full === 1'b1) full_seen = 1'b1;
        end
        wr_strobe = 1'b0;
        wait_idle(FRAME * 3, to);
        repeat (5) @(negedge clk);
        checks++;
        if (to || full_seen) begin
            failures++;
            $display("FAIL held_state timeout=%0d full_seen=%0d want 0 0", to, full_seen);
        end
        checks++;
        if (rx_data.size() != 1) begin
            failures++;
            $display("FAIL held_frames got=%0d want=1", rx_data.size());
        end
        while (exp_q.size() != 0 && rx_data.size() != 0) begin
            logic [7:0] ev, gv;
            bit ok;
            ev = exp_q.pop_front();
            gv = rx_data.pop_front();
            ok = rx_ok.pop_front();
            checks++;
            if (gv !== ev || !ok) begin
                failures++;
                $display("FAIL held_byte got=%h framing=%0d want=%h", gv, ok, ev);
            end
        end
        exp_q.delete(); rx_data.delete(); rx_ok.delete(); rx_start.delete();
    endtask

    task automatic test_back_to_back;
        bit to;
        strobe(16'h0001, 1'b1);
        strobe(16'h0002, 1'b1);
        strobe(16'h0003, 1'b1);
        wait_idle(FRAME * 4, to);
        checks++;
        if (to || rx_data.size() != 3) begin
            failures++;
            $display("FAIL b2b_frames timeout=%0d got=%0d want=3", to, rx_data.size());
        end
        for (int i = 1; i < rx_start.size(); i++) begin
            checks++;
            if (rx_start[i] - rx_start[i-1] != FRAME) begin
                failures++;
                $display("FAIL b2b_gap frame=%0d got=%0d want=%0d",
                         i, rx_start[i] - rx_start[i-1], FRAME);
            end
        end
        while (exp_q.size() != 0 && rx_data.size() != 0) begin
            logic [7:0] ev, gv;
            bit ok;
            ev = exp_q.pop_front();
            gv = rx_data.pop_front();
            ok = rx_ok.pop_front();
            checks++;
            if (gv !== ev || !ok) begin
                failures++;
                $display("FAIL b2b_byte got=%h framing=%0d want=%h", gv, ok, ev);
            end
        end
        exp_q.delete(); rx_data.delete(); rx_ok.delete(); rx_start.delete();
    endtask

    task automatic test_overflow;
        bit to;
        // First byte is popped at once; four fill the FIFO; the sixth drops.
        for (int i = 0; i < 6; i++) begin
            strobe(16'hAB10 + 16'(i), i < 5);
        end
        checks++;
        if (fifo_full !== 1'b1 || status !== (16'h000D | PAR_ST)) begin
            failures++;
            $display("FAIL ovf_set full=%b status=%h want 1 %h",
                     fifo_full, status, 16'h000D | PAR_ST);
        end
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++;
        if (status !== (16'h0005 | PAR_ST)) begin
            failures++;
            $display("FAIL ovf_clear status=%h want=%h", status, 16'h0005 | PAR_ST);
        end
        wait_idle(FRAME * 7, to);
        checks++;
        if (to || rx_data.size() != 5) begin
            failures++;
            $display("FAIL ovf_frames timeout=%0d got=%0d want=5", to, rx_data.size());
        end
        checks++;
        if (status !== IDLE_ST) begin
            failures++;
            $display("FAIL ovf_idle status=%h want=%h", status, IDLE_ST);
        end
        while (exp_q.size() != 0 && rx_data.size() != 0) begin
            logic [7:0] ev, gv;
            bit ok;
            ev = exp_q.pop_front();
            gv = rx_data.pop_front();
            ok = rx_ok.pop_front();
            checks++;
            if (gv !== ev || !ok) begin
                failures++;
                $display("FAIL ovf_byte got=%h framing=%0d want=%h", gv, ok, ev);
            end
        end
        exp_q.delete(); rx_data.delete(); rx_ok.delete(); rx_start.delete();
    endtask

    task automatic test_reset_mid;
        bit to;
        // 0x55 has bit 3 clear, so the line is low when reset hits.
        strobe(16'h0055, 1'b0);
        repeat (18) @(negedge clk);
        #1;
        checks++;
        if (txd !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre txd=%b busy=%b want 0 1", txd, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || status !== IDLE_ST) begin
            failures++;
            $display("FAIL rstmid_async txd=%b busy=%b status=%h want 1 0 %h",
                     txd, busy, status, IDLE_ST);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        strobe(16'h00FF, 1'b1);
        wait_idle(FRAME * 2, to);
        checks++;
        if (to || rx_data.size() != 1) begin
            failures++;
            $display("FAIL rstmid_frames timeout=%0d got=%0d want=1", to, rx_data.size());
        end
        while (exp_q.size() != 0 && rx_data.size() != 0) begin
            logic [7:0] ev, gv;
            bit ok;
            ev = exp_q.pop_front();
            gv = rx_data.pop_front();
            ok = rx_ok.pop_front();
            checks++;
            if (gv !== ev || !ok) begin
                failures++;
                $display("FAIL rstmid_byte got=%h framing=%0d want=%h", gv, ok, ev);
            end
        end
        exp_q.delete(); rx_data.delete(); rx_ok.delete(); rx_start.delete();
    endtask

`ifdef PORT_UART_TX_PARITY_EN
    task automatic test_parity;
        checks++;
        if (status[4] !== 1'b1) begin
            failures++;
            $display("FAIL parity_flag got=%b want=1", status[4]);
        end
        check_wave(16'h0007, "parity");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_held();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
`ifdef PORT_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
